// File: rtl/set_pkg.sv
// Shared types for the set-on-condition engine.
// Op encodings, FSM states and result width.
package set_pkg;

  localparam int RESULT_W = 32;

  typedef enum logic [2:0] {
    OP_SLT = 3'd0,
    OP_SEQ = 3'd1,
    OP_SNE = 3'd2,
    OP_SGT = 3'd3,
    OP_SLE = 3'd4,
    OP_SGE = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  function automatic logic cond_flag(
    input logic [2:0] op,
    input logic       lt,
    input logic       eq
  );
    logic f;
    f = 1'b0;
    case (op)
      OP_SLT:  f = lt;
      OP_SEQ:  f = eq;
      OP_SNE:  f = ~eq;
      OP_SGT:  f = ~lt & ~eq;
      OP_SLE:  f = lt | eq;
      OP_SGE:  f = ~lt;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// W-bit adder slice with carry in and out.
// Reused every CALC cycle on a different chunk.
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  assign {c_o, s_o} = {1'b0, x_i}
                    + {1'b0, y_i}
                    + {{W{1'b0}}, c_i};

endmodule

// File: rtl/set_cond_engine.sv
// Multi-cycle signed compare / set-on-condition.
// Computes A-B one chunk per cycle, then flags.
module set_cond_engine
  import set_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [31:0] diff,
  output logic        zf
);

  localparam int N  = RESULT_W / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e        state_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [2:0]    op_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q;
  logic [31:0]   diff_q;
  logic          zf_q;
  logic [31:0]   result_q;

  int             base;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] nb_ch;
  logic [CHUNK-1:0] sum;
  logic           co;
  logic           last;
  logic [31:0]    diff_d;
  logic           zf_d;
  logic           ovf;
  logic           lt;
  logic           flag_d;

  chunk_adder #(
    .W(CHUNK)
  ) u_add (
    .x_i(a_ch),
    .y_i(nb_ch),
    .c_i(carry_q),
    .s_o(sum),
    .c_o(co)
  );

  // Select the current chunk and fold its sum into diff/zf/flags.
  always_comb begin
    base   = int'(cnt_q) * CHUNK;
    a_ch   = a_q[base +: CHUNK];
    nb_ch  = ~b_q[base +: CHUNK];
    last   = (cnt_q == CW'(N - 1));
    diff_d = diff_q;
    diff_d[base +: CHUNK] = sum;
    zf_d   = zf_q & ~(|sum);
    ovf    = (a_q[31] & ~b_q[31] & ~diff_d[31])
           | (~a_q[31] & b_q[31] & diff_d[31]);
    lt     = diff_d[31] ^ ovf;
    flag_d = cond_flag(op_q, lt, zf_d);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      diff_q   <= '0;
      zf_q     <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            cnt_q   <= '0;
            carry_q <= 1'b1;
            zf_q    <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          diff_q  <= diff_d;
          zf_q    <= zf_d;
          carry_q <= co;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            result_q <= {31'b0, flag_d};
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign diff      = diff_q;
  assign zf        = zf_q;

endmodule

// File: doc/set_cond_engine.md
SET_COND_ENGINE -- requirements
Module: set_cond_engine

Interface
REQ-001 SHALL have parameter CHUNK, default 8, meaning bits subtracted per cycle; legal values are 1, 2, 4, 8, 16 and 32.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  engine can accept a request.
REQ-006 SHALL have port a  input  32  operand A, two's complement.
REQ-007 SHALL have port b  input  32  operand B, two's complement.
REQ-008 SHALL have port op  input  3  condition select: 0 SLT, 1 SEQ, 2 SNE, 3 SGT, 4 SLE, 5 SGE; 6 and 7 are illegal.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port result  output  32  condition result: bits 31:1 are zero, bit 0 is the flag.
REQ-012 SHALL have port diff  output  32  A-B difference, valid while out_valid is high.
REQ-013 SHALL have port zf  output  1  zero flag (diff == 0), valid while out_valid is high.

Function
REQ-014 SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-015 in_ready SHALL be high only in IDLE.
REQ-016 In IDLE with in_valid high: SHALL capture a, b and op, clear the chunk counter, set the carry register to 1 (subtract as A + ~B + 1) and move to CALC.
REQ-017 In CALC, each cycle SHALL add chunk k of A to chunk k of ~B plus the carry, store the sum into diff chunk k and the carry-out into the carry register, then increment k.
REQ-018 Chunk 0 SHALL be bits CHUNK-1:0 and chunks SHALL proceed toward the MSB.
REQ-019 CALC SHALL last exactly N = 32/CHUNK cycles; after chunk N-1 the engine SHALL move to DONE.
REQ-020 Latency SHALL be N+1 cycles from the accept edge to the out_valid rising edge.
REQ-021 SHALL accumulate zf as the NOR of all diff chunks computed so far; the result SHALL be final when entering DONE.
REQ-022 Signed flags: LT = diff[31] XOR V, where V = A[31]&~B[31]&~diff[31] | ~A[31]&B[31]&diff[31]; EQ = zf.
REQ-023 result[0] SHALL be:
  - SLT: LT
  - SEQ: EQ
  - SNE: ~EQ
  - SGT: ~LT & ~EQ
  - SLE: LT | EQ
  - SGE: ~LT
  - illegal op: result = 0, computed normally otherwise.
REQ-024 In DONE, out_valid SHALL be high, and result, diff and zf SHALL be held stable until out_ready is sampled high.
REQ-025 On DONE with out_ready high: SHALL go to IDLE, with in_ready high on the next cycle; back-to-back throughput is one request per N+2 cycles.
REQ-026 in_valid and operand changes during CALC or DONE SHALL be ignored; captured operands SHALL not change.
REQ-027 Carry out of chunk N-1 SHALL be discarded; the arithmetic is modulo 2^32.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, with out_valid=0, in_ready=1 after the deassert edge, and result=0, diff=0, zf=0, carry=0, counter=0.
REQ-029 Reset asserted mid-CALC or mid-DONE SHALL abandon the operation with no result emitted.
REQ-030 rst_n deassertion SHALL be synchronised to clk externally; the engine needs no extra cycles after release.

Structure
REQ-031 Op encodings, the state enumeration and the RESULT_W=32 constant SHALL live in shared package set_pkg.
REQ-032 The CHUNK-bit adder with carry in/out SHALL be one sub-module named chunk_adder, instantiated once.
REQ-033 SHALL contain no combinational path from in_valid to out_valid, or from out_ready to in_ready.

Verification
REQ-034 CHUNK=8, a=5, b=9, op=SLT -> out_valid on cycle 5 after accept; result=1, diff=0xFFFFFFFC, zf=0.
REQ-035 a=0x7FFFFFFF, b=0x80000000, op=SGT -> result=1; this exercises the overflow path, diff=0xFFFFFFFF, LT=0.
REQ-036 a=b=0x12345678, ops SEQ, SNE, SLE, SGE in sequence -> results 1, 0, 1, 1; zf=1; each op has N+2 spacing with out_ready held high.
REQ-037 out_ready held low for 10 cycles in DONE with in_valid and operands toggling -> result, diff and zf stable; in_ready stays 0; the new request is not accepted until one cycle after the handshake.
REQ-038 rst_n pulsed low during the 2nd CALC cycle -> out_valid never asserts; in_ready=1 after release; the next request a=3, b=3, op=SEQ returns result=1.
REQ-039 CHUNK=1 and CHUNK=32 runs of a=-1, b=1, op=SLT -> result=1 with latencies 33 and 2 respectively; op=7 -> result=0.
